// File: rtl/soc_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// soc_bus_arbiter_pkg
// Shared SoC bus definitions: the address map (inclusive base/limit per
// slave), the slave-index enum used to address bits of the one-hot select,
// the bus controller FSM state enum, the master identifier, and a range
// check helper used by every address decoder.
// -----------------------------------------------------------------------------
package soc_bus_arbiter_pkg;

   localparam int unsigned NUM_SLAVES = 4;

   // Inclusive address windows.
   localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
   localparam logic [31:0] MEM_LIMIT   = 32'h0002_7FFF;
   localparam logic [31:0] UART_BASE   = 32'h0010_0000;
   localparam logic [31:0] UART_LIMIT  = 32'h0010_000F;
   localparam logic [31:0] TIMER_BASE  = 32'h0020_0000;
   localparam logic [31:0] TIMER_LIMIT = 32'h0020_000F;
   localparam logic [31:0] GPIO_BASE   = 32'h0040_0000;
   localparam logic [31:0] GPIO_LIMIT  = 32'h0040_000F;

   // Bit position of each slave inside the one-hot select.
   typedef enum logic [1:0] {
      SLV_MEM   = 2'd0,
      SLV_UART  = 2'd1,
      SLV_TIMER = 2'd2,
      SLV_GPIO  = 2'd3
   } slave_idx_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2,
      ST_ERR    = 2'd3
   } bus_state_e;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } master_e;

   // Inclusive window test; arguments are variables so a zero base does not
   // turn into a constant-true comparison.
   function automatic logic in_region(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
      return (addr >= base) && (addr <= limit);
   endfunction

endpackage

// File: rtl/soc_addr_decode.sv
// -----------------------------------------------------------------------------
// soc_addr_decode
// Purely combinational SoC address decoder, shared by all bus masters.
// Ports:
//   addr  in  32  byte address
//   sel   out 4   one-hot slave select (bit0 mem, bit1 uart, bit2 timer,
//                 bit3 gpio); all zero when unmapped
//   hit   out 1   address falls inside one of the mapped windows
// -----------------------------------------------------------------------------
module soc_addr_decode
   import soc_bus_arbiter_pkg::*;
(
   input  logic [31:0]           addr,
   output logic [NUM_SLAVES-1:0] sel,
   output logic                  hit
);

   always_comb begin
      // NOTE: every output gets a default before any condition so no path
      // leaves it unassigned, which is what keeps this block latch-free.
      sel = '0;
      sel[SLV_MEM]   = in_region(addr, MEM_BASE,   MEM_LIMIT);
      sel[SLV_UART]  = in_region(addr, UART_BASE,  UART_LIMIT);
      sel[SLV_TIMER] = in_region(addr, TIMER_BASE, TIMER_LIMIT);
      sel[SLV_GPIO]  = in_region(addr, GPIO_BASE,  GPIO_LIMIT);
      hit = |sel;
   end

endmodule

// File: rtl/soc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// soc_bus_arbiter
// Two-master / four-slave SoC bus controller. Round-robin arbitration between
// m0 (instruction fetch) and m1 (data), address decode to a one-hot slave
// select, one transaction at a time with a ready timeout, and a single-cycle
// response (data or error) returned only to the owning master.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   mX_req/addr/we/be/wdata   master request and payload (held until gnt)
//   mX_gnt                combinational grant pulse in IDLE
//   mX_rvalid/rdata/err   single-cycle response to the owner
//   s_req, s_sel          active transaction and one-hot slave select
//   s_addr/we/be/wdata    latched transaction controls
//   s_rdata_*             per-slave read data
//   s_ready               per-slave completion, masked by s_sel
// Parameter:
//   TIMEOUT               ACCESS cycles without ready before abort (2..255)
// -----------------------------------------------------------------------------
module soc_bus_arbiter
   import soc_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic        m0_we,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,

   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic        m1_we,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,

   output logic        s_req,
   output logic [3:0]  s_sel,
   output logic [31:0] s_addr,
   output logic        s_we,
   output logic [3:0]  s_be,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata_mem,
   input  logic [31:0] s_rdata_uart,
   input  logic [31:0] s_rdata_timer,
   input  logic [31:0] s_rdata_gpio,
   input  logic [3:0]  s_ready
);

   // Counter value of the last ACCESS cycle before the abort.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   bus_state_e            state_q, state_d;
   logic [7:0]            cnt_q,   cnt_d;
   master_e               last_q,  last_d;
   master_e               owner_q, owner_d;
   logic [31:0]           addr_q,  addr_d;
   logic                  we_q,    we_d;
   logic [3:0]            be_q,    be_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [NUM_SLAVES-1:0] sel_q,   sel_d;
   logic [31:0]           rdata_q, rdata_d;

   // ---------------------------------------------------------------------------
   // Arbitration: lone requester wins; on a tie the master not granted last.
   // ---------------------------------------------------------------------------
   logic        any_req;
   master_e     win;
   logic [31:0] win_addr;
   logic        win_we;
   logic [3:0]  win_be;
   logic [31:0] win_wdata;

   always_comb begin
      any_req = m0_req | m1_req;
      if (m0_req && m1_req) begin
         win = (last_q == OWN_M1) ? OWN_M0 : OWN_M1;
      end else if (m1_req) begin
         win = OWN_M1;
      end else begin
         win = OWN_M0;
      end
      win_addr  = (win == OWN_M1) ? m1_addr  : m0_addr;
      win_we    = (win == OWN_M1) ? m1_we    : m0_we;
      win_be    = (win == OWN_M1) ? m1_be    : m0_be;
      win_wdata = (win == OWN_M1) ? m1_wdata : m0_wdata;
   end

   logic [NUM_SLAVES-1:0] dec_sel;
   logic                  dec_hit;

   soc_addr_decode u_decode (
      .addr (win_addr),
      .sel  (dec_sel),
      .hit  (dec_hit)
   );

   // ---------------------------------------------------------------------------
   // Slave response selection; a ready from an unselected slave is masked off.
   // ---------------------------------------------------------------------------
   logic        ready_hit;
   logic [31:0] sel_rdata;

   always_comb begin
      ready_hit = |(s_ready & sel_q);
      sel_rdata = '0;
      if (sel_q[SLV_MEM])   sel_rdata = s_rdata_mem;
      if (sel_q[SLV_UART])  sel_rdata = s_rdata_uart;
      if (sel_q[SLV_TIMER]) sel_rdata = s_rdata_timer;
      if (sel_q[SLV_GPIO])  sel_rdata = s_rdata_gpio;
   end

   // ---------------------------------------------------------------------------
   // FSM next state and master-side outputs.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      we_d      = we_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      sel_d     = sel_q;
      rdata_d   = rdata_q;
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      m0_err    = 1'b0;
      m1_err    = 1'b0;
      m0_rdata  = '0;
      m1_rdata  = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               m0_gnt  = (win == OWN_M0);
               m1_gnt  = (win == OWN_M1);
               last_d  = win;
               owner_d = win;
               addr_d  = win_addr;
               we_d    = win_we;
               be_d    = win_be;
               wdata_d = win_wdata;
               sel_d   = dec_sel;
               cnt_d   = '0;
               rdata_d = '0;
               state_d = dec_hit ? ST_ACCESS : ST_ERR;
            end
         end

         ST_ACCESS: begin
            // Ready is checked first so it wins over a coinciding timeout.
            if (ready_hit) begin
               rdata_d = we_q ? 32'h0 : sel_rdata;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_RESP: begin
            m0_rvalid = (owner_q == OWN_M0);
            m1_rvalid = (owner_q == OWN_M1);
            m0_rdata  = (owner_q == OWN_M0) ? rdata_q : 32'h0;
            m1_rdata  = (owner_q == OWN_M1) ? rdata_q : 32'h0;
            state_d   = ST_IDLE;
         end

         ST_ERR: begin
            m0_rvalid = (owner_q == OWN_M0);
            m1_rvalid = (owner_q == OWN_M1);
            m0_err    = (owner_q == OWN_M0);
            m1_err    = (owner_q == OWN_M1);
            state_d   = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Slave-side outputs. The select is only driven while ACCESS is active so
   // an abandoned or failed transaction never shows a stale select.
   // ---------------------------------------------------------------------------
   always_comb begin
      s_req   = (state_q == ST_ACCESS);
      s_sel   = s_req ? sel_q : '0;
      s_addr  = addr_q;
      s_we    = we_q;
      s_be    = be_q;
      s_wdata = wdata_q;
   end

   // ---------------------------------------------------------------------------
   // State registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge, independent of statement
      // order.
      if (reset) begin
         // NOTE: this block holds only control and a single transaction's
         // latched payload (no storage arrays), so every flop is reset to give
         // a clean, fully-defined bus after reset.
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= OWN_M1;
         owner_q <= OWN_M0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_soc_bus_arbiter
// Directed self-checking bench for soc_bus_arbiter (TIMEOUT = 16). Inputs are
// driven 1 ns after the rising edge; outputs are checked 1 ns later, well away
// from the next edge. Cycle numbers in comments count from the grant cycle.
// -----------------------------------------------------------------------------
module tb_soc_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m1_addr;
   logic        m0_we, m1_we;
   logic [3:0]  m0_be, m1_be;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m1_gnt;
   logic        m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_err, m1_err;
   logic        s_req;
   logic [3:0]  s_sel;
   logic [31:0] s_addr;
   logic        s_we;
   logic [3:0]  s_be;
   logic [31:0] s_wdata;
   logic [31:0] s_rdata_mem, s_rdata_uart, s_rdata_timer, s_rdata_gpio;
   logic [3:0]  s_ready;

   int checks;
   int failures;
   int w;

   soc_bus_arbiter #(.TIMEOUT(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .m0_req        (m0_req),
      .m0_addr       (m0_addr),
      .m0_we         (m0_we),
      .m0_be         (m0_be),
      .m0_wdata      (m0_wdata),
      .m0_gnt        (m0_gnt),
      .m0_rvalid     (m0_rvalid),
      .m0_rdata      (m0_rdata),
      .m0_err        (m0_err),
      .m1_req        (m1_req),
      .m1_addr       (m1_addr),
      .m1_we         (m1_we),
      .m1_be         (m1_be),
      .m1_wdata      (m1_wdata),
      .m1_gnt        (m1_gnt),
      .m1_rvalid     (m1_rvalid),
      .m1_rdata      (m1_rdata),
      .m1_err        (m1_err),
      .s_req         (s_req),
      .s_sel         (s_sel),
      .s_addr        (s_addr),
      .s_we          (s_we),
      .s_be          (s_be),
      .s_wdata       (s_wdata),
      .s_rdata_mem   (s_rdata_mem),
      .s_rdata_uart  (s_rdata_uart),
      .s_rdata_timer (s_rdata_timer),
      .s_rdata_gpio  (s_rdata_gpio),
      .s_ready       (s_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_be = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_be = '0; m1_wdata = '0;
      s_rdata_mem = '0; s_rdata_uart = '0; s_rdata_timer = '0; s_rdata_gpio = '0;
      s_ready = '0;

      // ---- Reset state ----
      tick(); tick(); settle();
      check("rst_gnt",    {m0_gnt, m1_gnt}, 0);
      check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
      check("rst_err",    {m0_err, m1_err}, 0);
      check("rst_rdata",  m0_rdata | m1_rdata, 0);
      check("rst_s_req",  s_req, 0);
      check("rst_s_sel",  s_sel, 0);
      check("rst_s_addr", s_addr, 0);
      check("rst_s_ctl",  {s_we, s_be}, 0);
      check("rst_s_wdat", s_wdata, 0);
      reset = 1'b0;
      tick();

      // ---- Three tie rounds: grants m0, m1, m0 ----
      m0_addr = 32'h0000_0200; m1_addr = 32'h0000_0300;
      m0_req = 1'b1; m1_req = 1'b1;
      for (int r = 0; r < 3; r++) begin
         w = r % 2;
         settle();
         check("tie_gnt_m0", m0_gnt, (w == 0));
         check("tie_gnt_m1", m1_gnt, (w == 1));
         tick();
         if (w == 0) m0_req = 1'b0; else m1_req = 1'b0;
         s_ready = 4'b0001;
         s_rdata_mem = 32'hC0DE_0000 + r;
         settle();
         check("tie_s_addr", s_addr, (w == 1) ? 32'h0000_0300 : 32'h0000_0200);
         check("tie_no_gnt_access", {m0_gnt, m1_gnt}, 0);
         tick();
         s_ready = 4'b0000;
         if (r < 2) begin
            if (w == 0) m0_req = 1'b1; else m1_req = 1'b1;
         end else begin
            m0_req = 1'b0; m1_req = 1'b0;
         end
         settle();
         check("tie_rvalid_m0", m0_rvalid, (w == 0));
         check("tie_rvalid_m1", m1_rvalid, (w == 1));
         check("tie_rdata", (w == 1) ? m1_rdata : m0_rdata, 32'hC0DE_0000 + r);
         check("tie_no_gnt_resp", {m0_gnt, m1_gnt}, 0);
         tick();
      end

      // ---- m0 read of mem 0x100, ready in cycle 1 ----
      m0_req = 1'b1; m0_addr = 32'h0000_0100; m0_we = 1'b0; m0_be = 4'hF;
      settle();
      check("rd_gnt_c0", {m0_gnt, m1_gnt}, 2'b10);
      check("rd_s_req_c0", s_req, 0);
      tick();                                   // cycle 1
      m0_req = 1'b0; s_ready = 4'b0001; s_rdata_mem = 32'hDEAD_BEEF;
      settle();
      check("rd_s_req_c1", s_req, 1);
      check("rd_s_sel", s_sel, 4'b0001);
      check("rd_s_addr", s_addr, 32'h0000_0100);
      check("rd_s_we", s_we, 0);
      tick();                                   // cycle 2
      s_ready = 4'b0000;
      settle();
      check("rd_rvalid_c2", {m0_rvalid, m1_rvalid}, 2'b10);
      check("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
      check("rd_err", m0_err, 0);
      check("rd_s_req_c2", s_req, 0);
      tick();                                   // cycle 3
      check("rd_rvalid_c3", m0_rvalid, 0);

      // ---- m1 write to gpio 0x0040_0004; wrong-slave ready ignored ----
      m1_req = 1'b1; m1_addr = 32'h0040_0004; m1_we = 1'b1; m1_be = 4'h3;
      m1_wdata = 32'h0000_1234;
      settle();
      check("wr_gnt", {m0_gnt, m1_gnt}, 2'b01);
      tick();                                   // cycle 1
      m1_req = 1'b0; m1_wdata = 32'hFFFF_FFFF; m1_be = 4'hF;
      s_ready = 4'b0111; s_rdata_gpio = 32'h5555_AAAA;
      settle();
      check("wr_s_sel", s_sel, 4'b1000);
      check("wr_s_we", s_we, 1);
      check("wr_s_be", s_be, 4'h3);
      check("wr_s_wdata", s_wdata, 32'h0000_1234);
      check("wr_s_addr", s_addr, 32'h0040_0004);
      tick();                                   // cycle 2
      s_ready = 4'b1000;
      settle();
      check("wr_unsel_ready_ignored", {s_req, m1_rvalid}, 2'b10);
      tick();                                   // cycle 3
      s_ready = 4'b0000;
      settle();
      check("wr_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
      check("wr_rdata_zero", m1_rdata, 0);
      check("wr_err", m1_err, 0);
      tick();

      // ---- m1 unmapped 0x0003_0000 ----
      m1_req = 1'b1; m1_addr = 32'h0003_0000; m1_we = 1'b0;
      settle();
      check("um_gnt", m1_gnt, 1);
      check("um_s_req_c0", s_req, 0);
      tick();                                   // cycle 1
      m1_req = 1'b0;
      settle();
      check("um_s_req_c1", s_req, 0);
      check("um_rvalid_err", {m1_rvalid, m1_err, m0_rvalid}, 3'b110);
      check("um_rdata", m1_rdata, 0);
      tick();

      // ---- UART timeout: error exactly in cycle 17 ----
      m0_req = 1'b1; m0_addr = 32'h0010_0000; m0_we = 1'b0;
      s_rdata_uart = 32'h0000_00A5;
      settle();
      check("to_gnt", m0_gnt, 1);
      for (int c = 1; c <= 16; c++) begin
         tick();
         m0_req = 1'b0; s_ready = 4'b1101;
         settle();
         check("to_access_wait", {s_req, m0_rvalid, m0_err}, 3'b100);
      end
      tick();                                   // cycle 17
      s_ready = 4'b0000;
      settle();
      check("to_rvalid_err_c17", {m0_rvalid, m0_err, m1_rvalid}, 3'b110);
      check("to_rdata", m0_rdata, 0);
      check("to_s_req", s_req, 0);
      tick();

      // ---- UART ready in the final counted cycle (16) wins ----
      m0_req = 1'b1;
      settle();
      check("tr_gnt", m0_gnt, 1);
      for (int c = 1; c <= 16; c++) begin
         tick();
         m0_req = 1'b0;
         s_ready = (c == 16) ? 4'b0010 : 4'b0000;
         settle();
         check("tr_no_early_resp", m0_rvalid, 0);
      end
      tick();                                   // cycle 17
      s_ready = 4'b0000;
      settle();
      check("tr_rvalid_c17", {m0_rvalid, m0_err}, 2'b10);
      check("tr_rdata", m0_rdata, 32'h0000_00A5);
      tick();

      // ---- Reset during ACCESS, then first tie goes to m0 ----
      m0_req = 1'b1; m0_addr = 32'h0020_0008; m0_we = 1'b0;
      settle();
      check("mr_gnt", m0_gnt, 1);
      tick();                                   // cycle 1
      m0_req = 1'b0;
      settle();
      check("mr_s_sel", {s_req, s_sel}, 5'b1_0100);
      tick();                                   // cycle 2: reset with ready
      reset = 1'b1; s_ready = 4'b0100; s_rdata_timer = 32'h7777_7777;
      tick();                                   // cycle 3
      reset = 1'b0; s_ready = 4'b0000;
      settle();
      check("mr_s_req_zero", s_req, 0);
      check("mr_s_sel_zero", s_sel, 0);
      check("mr_no_rvalid_c3", {m0_rvalid, m1_rvalid}, 0);
      tick();                                   // cycle 4
      check("mr_no_rvalid_c4", {m0_rvalid, m1_rvalid}, 0);
      m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h0000_0010;
      settle();
      check("mr_tie_gnt_m0", {m0_gnt, m1_gnt}, 2'b10);
      tick();
      m0_req = 1'b0; m1_req = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
